// File: rtl/izhikevich_scheduler.sv
// Time-multiplexes one Izhikevich integration core across NEURONS neurons.
// Holds per-neuron v/w/i banks and walks LOAD/APPLY/CAPTURE per neuron on each start.
`timescale 1ns/1ps
module izhikevich_scheduler #(
  parameter int N       = 20,
  parameter int Q       = 10,
  parameter int NEURONS = 8,
  parameter int IDX_W   = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  input  logic                 i_cfg_we,
  input  logic [IDX_W-1:0]     i_cfg_idx,
  input  logic [N-1:0]         i_cfg_v,
  input  logic [N-1:0]         i_cfg_w,
  input  logic                 i_i_we,
  input  logic [IDX_W-1:0]     i_i_idx,
  input  logic [N-1:0]         i_i_val,
  input  logic [IDX_W-1:0]     i_rd_idx,
  output logic [N-1:0]         o_rd_v,
  output logic [N-1:0]         o_rd_w,
  output logic [NEURONS-1:0]   o_spike_vector,
  output logic [15:0]          o_step_count,
  output logic                 o_core_rst,
  output logic                 o_core_apply,
  output logic [N-1:0]         o_core_v_init,
  output logic [N-1:0]         o_core_w_init,
  output logic [N-1:0]         o_core_i,
  input  logic [N-1:0]         i_core_voltage,
  input  logic [N-1:0]         i_core_w,
  input  logic                 i_core_is_spiking
);

  localparam int AW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  if (Q >= N || NEURONS < 2 || IDX_W < AW) begin : g_param_check
    $error("izhikevich_scheduler: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [N-1:0]        r_v_bank [NEURONS];
  logic [N-1:0]        r_w_bank [NEURONS];
  logic [N-1:0]        r_i_bank [NEURONS];
  logic [IDX_W-1:0]    r_k;
  logic [NEURONS-1:0]  r_spike_shadow;
  logic [NEURONS-1:0]  r_spike_vector;
  logic [15:0]         r_step_count;

  logic                w_last;
  logic                w_cfg_ok;
  logic                w_i_ok;
  logic                w_rd_ok;
  logic [AW-1:0]       w_k;

  assign w_k      = r_k[AW-1:0];
  assign w_last   = (r_k == IDX_W'(NEURONS - 1));
  // Out-of-range indices are dropped rather than aliased onto a real neuron.
  assign w_cfg_ok = i_cfg_we && (r_state == S_IDLE) && (int'(i_cfg_idx) < NEURONS);
  assign w_i_ok   = i_i_we && (int'(i_i_idx) < NEURONS);
  assign w_rd_ok  = int'(i_rd_idx) < NEURONS;

  assign o_rd_v         = w_rd_ok ? r_v_bank[i_rd_idx[AW-1:0]] : '0;
  assign o_rd_w         = w_rd_ok ? r_w_bank[i_rd_idx[AW-1:0]] : '0;
  assign o_spike_vector = r_spike_vector;
  assign o_step_count   = r_step_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: defaults first in every always_comb so no path leaves an output
  // unassigned and infers a latch.
  always_comb begin
    w_next        = r_state;
    o_busy        = (r_state != S_IDLE);
    o_done        = 1'b0;
    o_core_rst    = 1'b0;
    o_core_apply  = 1'b0;
    o_core_v_init = '0;
    o_core_w_init = '0;
    o_core_i      = '0;
    case (r_state)
      S_IDLE:    if (i_start) w_next = S_LOAD;
      S_LOAD: begin
        o_core_rst    = 1'b1;
        o_core_v_init = r_v_bank[w_k];
        o_core_w_init = r_w_bank[w_k];
        w_next        = S_APPLY;
      end
      S_APPLY: begin
        o_core_apply = 1'b1;
        o_core_i     = r_i_bank[w_k];
        w_next       = S_CAPTURE;
      end
      S_CAPTURE: w_next = w_last ? S_DONE : S_LOAD;
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: the banks are small register files, not RAM macros, so they are
  // cleared on reset like any other state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k            <= '0;
      r_spike_shadow <= '0;
      r_spike_vector <= '0;
      r_step_count   <= '0;
      for (int n = 0; n < NEURONS; n++) begin
        r_v_bank[n] <= '0;
        r_w_bank[n] <= '0;
        r_i_bank[n] <= '0;
      end
    end else begin
      if (w_cfg_ok) begin
        r_v_bank[i_cfg_idx[AW-1:0]] <= i_cfg_v;
        r_w_bank[i_cfg_idx[AW-1:0]] <= i_cfg_w;
      end
      if (w_i_ok) r_i_bank[i_i_idx[AW-1:0]] <= i_i_val;
      case (r_state)
        S_IDLE: if (i_start) r_k <= '0;
        S_CAPTURE: begin
          r_v_bank[w_k]       <= i_core_voltage;
          r_w_bank[w_k]       <= i_core_w;
          r_spike_shadow[w_k] <= i_core_is_spiking;
          if (!w_last) r_k <= r_k + IDX_W'(1);
        end
        S_DONE: begin
          r_spike_vector <= r_spike_shadow;
          r_step_count   <= r_step_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_izhikevich_scheduler.sv
// Bench for izhikevich_scheduler: behavioural Izhikevich core plus a bank model;
// per-sweep expectations are queued at start and compared after done.
`timescale 1ns/1ps
module tb_izhikevich_scheduler;

  localparam int N       = 20;
  localparam int Q       = 10;
  localparam int NEURONS = 8;
  localparam int IDX_W   = 4;

  localparam logic [N-1:0] V_REST  = 20'hEFC00;  // -65.0
  localparam logic [N-1:0] W_INIT  = 20'hFCC00;  // -13.0
  localparam logic [N-1:0] I_VAL   = 20'h02800;  //  10.0
  localparam logic [N-1:0] V_HIGH  = 20'h08C00;  //  35.0
  localparam logic [N-1:0] C_RESET = 20'hEFC00;  // -65.0
  localparam logic [N-1:0] D_INC   = 20'h02000;  //   8.0
  localparam logic [N-1:0] W_SPK   = 20'hFEC00;  // -13.0 + 8.0
  localparam logic [N-1:0] I_NEW   = 20'h01400;  //   5.0

  logic               clk;
  logic               rst;
  logic               start;
  logic               busy;
  logic               done;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [N-1:0]       cfg_v;
  logic [N-1:0]       cfg_w;
  logic               i_we;
  logic [IDX_W-1:0]   i_idx;
  logic [N-1:0]       i_val;
  logic [IDX_W-1:0]   rd_idx;
  logic [N-1:0]       rd_v;
  logic [N-1:0]       rd_w;
  logic [NEURONS-1:0] spike_vector;
  logic [15:0]        step_count;
  logic               core_rst;
  logic               core_apply;
  logic [N-1:0]       core_v_init;
  logic [N-1:0]       core_w_init;
  logic [N-1:0]       core_i;
  logic [N-1:0]       core_voltage;
  logic [N-1:0]       core_w;
  logic               core_is_spiking;

  izhikevich_scheduler #(.N(N), .Q(Q), .NEURONS(NEURONS), .IDX_W(IDX_W)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_start           (start),
    .o_busy            (busy),
    .o_done            (done),
    .i_cfg_we          (cfg_we),
    .i_cfg_idx         (cfg_idx),
    .i_cfg_v           (cfg_v),
    .i_cfg_w           (cfg_w),
    .i_i_we            (i_we),
    .i_i_idx           (i_idx),
    .i_i_val           (i_val),
    .i_rd_idx          (rd_idx),
    .o_rd_v            (rd_v),
    .o_rd_w            (rd_w),
    .o_spike_vector    (spike_vector),
    .o_step_count      (step_count),
    .o_core_rst        (core_rst),
    .o_core_apply      (core_apply),
    .o_core_v_init     (core_v_init),
    .o_core_w_init     (core_w_init),
    .o_core_i          (core_i),
    .i_core_voltage    (core_voltage),
    .i_core_w          (core_w),
    .i_core_is_spiking (core_is_spiking)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One Euler step, a=0.02 b=0.2 c=-65 d=8 dt=0.1 v_th=30, Q10 words.
  function automatic void core_step(input logic [N-1:0] v, input logic [N-1:0] w,
                                    input logic [N-1:0] i, output logic [N-1:0] vn,
                                    output logic [N-1:0] wn, output logic spk);
    real vr, wr, ir, dv, dw;
    vr = $itor($signed(v)) / 1024.0;
    wr = $itor($signed(w)) / 1024.0;
    ir = $itor($signed(i)) / 1024.0;
    if (vr >= 30.0) begin
      vn  = C_RESET;
      wn  = w + D_INC;
      spk = 1'b1;
    end else begin
      dv  = 0.04 * vr * vr + 5.0 * vr + 140.0 - wr + ir;
      dw  = 0.02 * (0.2 * vr - wr);
      vn  = N'($rtoi((vr + 0.1 * dv) * 1024.0));
      wn  = N'($rtoi((wr + 0.1 * dw) * 1024.0));
      spk = 1'b0;
    end
  endfunction

  // Behavioural shared core: loads on core_rst, integrates on core_apply.
  always @(posedge clk) begin : core_model
    logic [N-1:0] nv, nw;
    logic         ns;
    if (core_rst) begin
      core_voltage    <= core_v_init;
      core_w          <= core_w_init;
      core_is_spiking <= 1'b0;
    end else if (core_apply) begin
      core_step(core_voltage, core_w, core_i, nv, nw, ns);
      core_voltage    <= nv;
      core_w          <= nw;
      core_is_spiking <= ns;
    end
  end

  initial begin
    core_voltage    = '0;
    core_w          = '0;
    core_is_spiking = 1'b0;
  end

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] w;
  } exp_t;

  exp_t               sb_q[$];
  logic [NEURONS-1:0] spk_q[$];
  logic [N-1:0]       m_v [NEURONS];
  logic [N-1:0]       m_w [NEURONS];
  logic [N-1:0]       m_i [NEURONS];
  logic [15:0]        m_cnt;
  int                 n_checks;
  int                 n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NEURONS; k++) begin
      m_v[k] = '0;
      m_w[k] = '0;
      m_i[k] = '0;
    end
  endtask

  task automatic write_neuron(input int idx, input logic [N-1:0] v, input logic [N-1:0] w,
                              input logic [N-1:0] i);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_v = v; cfg_w = w;
    i_we   = 1'b1; i_idx   = IDX_W'(idx); i_val = i;
    tick();
    cfg_we = 1'b0;
    i_we   = 1'b0;
    if (idx < NEURONS) begin
      m_v[idx] = v;
      m_w[idx] = w;
      m_i[idx] = i;
    end
  endtask

  task automatic predict_sweep();
    exp_t               e;
    logic               s;
    logic [NEURONS-1:0] spk;
    spk = '0;
    for (int k = 0; k < NEURONS; k++) begin
      core_step(m_v[k], m_w[k], m_i[k], e.v, e.w, s);
      spk[k] = s;
      m_v[k] = e.v;
      m_w[k] = e.w;
      sb_q.push_back(e);
    end
    spk_q.push_back(spk);
    m_cnt = m_cnt + 16'd1;
  endtask

  task automatic read_bank(input int idx, output logic [N-1:0] v, output logic [N-1:0] w);
    rd_idx = IDX_W'(idx);
    @(negedge clk);
    v = rd_v;
    w = rd_w;
  endtask

  task automatic check_results(input string tag);
    exp_t         e;
    logic [N-1:0] v, w;
    for (int k = 0; k < NEURONS; k++) begin
      e = sb_q.pop_front();
      read_bank(k, v, w);
      check($sformatf("%s rd_v[%0d]", tag, k), 32'(v), 32'(e.v));
      check($sformatf("%s rd_w[%0d]", tag, k), 32'(w), 32'(e.w));
    end
    check({tag, " spike_vector"}, 32'(spike_vector), 32'(spk_q.pop_front()));
    check({tag, " step_count"}, 32'(step_count), 32'(m_cnt));
  endtask

  // Runs one sweep; optionally issues a cfg write on the same edge as start.
  task automatic run_sweep(input string tag, input bit with_cfg, input int idx,
                           input logic [N-1:0] v, input logic [N-1:0] w);
    int cyc;
    start = 1'b1;
    if (with_cfg) begin
      cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_v = v; cfg_w = w;
      m_v[idx] = v;
      m_w[idx] = w;
    end
    predict_sweep();
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    cyc    = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, " done cycle"}, 32'(cyc), 32'd25);
    tick();
    check({tag, " busy after done"}, 32'(busy), 32'd0);
    check_results(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] v, w;
    logic [N-1:0] old_i5;
    int           n_done;
    int           done_at;

    n_checks = 0;
    n_fail   = 0;
    m_cnt    = '0;
    model_clear();
    start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_v = '0; cfg_w = '0;
    i_we  = 1'b0; i_idx  = '0;   i_val   = '0; rd_idx = '0;

    // Reset with random inputs.
    rst = 1'b1;
    repeat (2) begin
      start  = 1'($urandom); cfg_we = 1'($urandom); cfg_idx = IDX_W'($urandom);
      cfg_v  = N'($urandom); cfg_w  = N'($urandom); i_we    = 1'($urandom);
      i_idx  = IDX_W'($urandom); i_val = N'($urandom);
      tick();
    end
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset spike_vector", 32'(spike_vector), 32'd0);
    check("reset step_count", 32'(step_count), 32'd0);
    check("reset core_rst", 32'(core_rst), 32'd0);
    check("reset core_apply", 32'(core_apply), 32'd0);
    check("reset core_v_init", 32'(core_v_init), 32'd0);
    check("reset core_w_init", 32'(core_w_init), 32'd0);
    check("reset core_i", 32'(core_i), 32'd0);
    for (int k = 0; k < NEURONS; k++) begin
      read_bank(k, v, w);
      check($sformatf("reset rd_v[%0d]", k), 32'(v), 32'd0);
      check($sformatf("reset rd_w[%0d]", k), 32'(w), 32'd0);
    end
    start = 1'b0; cfg_we = 1'b0; i_we = 1'b0;
    rst   = 1'b0;
    tick();

    // Reset mid-sweep at cycle 10.
    for (int k = 0; k < NEURONS; k++) write_neuron(k, V_REST, W_INIT, I_VAL);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n_done = 0;
    for (int c = 1; c < 10; c++) begin
      if (done) n_done++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst done count", 32'(n_done), 32'd0);
    check("midrst step_count", 32'(step_count), 32'd0);
    for (int k = 0; k < NEURONS; k++) begin
      read_bank(k, v, w);
      check($sformatf("midrst rd_v[%0d]", k), 32'(v), 32'd0);
      check($sformatf("midrst rd_w[%0d]", k), 32'(w), 32'd0);
    end

    // Single sweep from rest; neuron 7's state is written on the start edge.
    for (int k = 0; k < NEURONS; k++) write_neuron(k, 20'h0, 20'h0, I_VAL);
    for (int k = 0; k < NEURONS - 1; k++) write_neuron(k, V_REST, W_INIT, I_VAL);
    run_sweep("sweep1", 1'b1, NEURONS - 1, V_REST, W_INIT);

    // Spike path on neuron 3.
    for (int k = 0; k < NEURONS; k++)
      write_neuron(k, (k == 3) ? V_HIGH : V_REST, W_INIT, I_VAL);
    run_sweep("spike", 1'b0, 0, '0, '0);
    check("spike vector 0x08", 32'(spike_vector), 32'h08);
    read_bank(3, v, w);
    check("spike rd_v[3]=c", 32'(v), 32'(C_RESET));
    check("spike rd_w[3]=w+d", 32'(w), 32'(W_SPK));
    run_sweep("after_spike", 1'b0, 0, '0, '0);
    check("after_spike bit3", 32'(spike_vector[3]), 32'd0);

    // Protocol: cfg_we/start during busy ignored; i_we in neuron 5's APPLY.
    old_i5  = m_i[5];
    start   = 1'b1;
    predict_sweep();
    tick();
    start   = 1'b0;
    n_done  = 0;
    done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        n_done++;
        done_at = c;
      end
      if (c == 2) begin
        check("proto apply excl rst", 32'(core_rst), 32'd0);
        check("proto v_init zero in APPLY", 32'(core_v_init), 32'd0);
        check("proto core_i neuron0", 32'(core_i), 32'(m_i[0]));
      end
      if (c == 5 || c == 10) start = 1'b1;
      if (c == 5) begin
        cfg_we = 1'b1; cfg_idx = 4'd2; cfg_v = 20'h12345; cfg_w = 20'h54321;
      end
      if (c == 17) begin
        i_we = 1'b1; i_idx = 4'd5; i_val = I_NEW;
        #1;
        check("proto apply at 17", 32'(core_apply), 32'd1);
        check("proto core_i old", 32'(core_i), 32'(old_i5));
      end
      tick();
      start  = 1'b0;
      cfg_we = 1'b0;
      i_we   = 1'b0;
    end
    check("proto done count", 32'(n_done), 32'd1);
    check("proto done cycle", 32'(done_at), 32'd25);
    check_results("proto");
    m_i[5] = I_NEW;
    run_sweep("new_i", 1'b0, 0, '0, '0);

    // Step counter wrap and out-of-range index.
    @(negedge clk);
    force dut.r_step_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_step_count;
    m_cnt = 16'hFFFF;
    tick();
    check("wrap preload", 32'(step_count), 32'hFFFF);
    run_sweep("wrap", 1'b0, 0, '0, '0);
    check("wrap zero", 32'(step_count), 32'd0);
    write_neuron(9, 20'h11111, 20'h22222, 20'h33333);
    read_bank(9, v, w);
    check("oob rd_v[9]", 32'(v), 32'd0);
    for (int k = 0; k < NEURONS; k++) begin
      read_bank(k, v, w);
      check($sformatf("oob rd_v[%0d]", k), 32'(v), 32'(m_v[k]));
      check($sformatf("oob rd_w[%0d]", k), 32'(w), 32'(m_w[k]));
    end
    run_sweep("after_oob", 1'b0, 0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
